// File: rtl/axis_pipe_chain_pkg.sv
// Shared helpers for the AXI-Stream register chain: sizing of the occupancy counter.
package axis_pipe_chain_pkg;

    // One count value per storage slot plus zero; a chain with no slots still gets one bit.
    function automatic int occ_width(input int depth, input int reg_ready);
        int slots;
        slots = depth * (1 + reg_ready);
        return (slots == 0) ? 1 : $clog2(slots + 1);
    endfunction

endpackage

// File: rtl/axis_pipe_chain_skid_stage.sv
// One AXI-Stream register slice: a plain valid/data register, or a 2-entry skid buffer
// whose upstream ready comes straight from a flop.
module axis_skid_stage #(
    parameter int WIDTH     = 32,
    parameter int REG_READY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    if (REG_READY != 0) begin : g_skid
        logic             mv_q, mv_d;
        logic             sv_q, sv_d;
        logic [WIDTH-1:0] md_q, md_d;
        logic [WIDTH-1:0] sd_q, sd_d;
        logic             accept;

        assign accept = s_valid & ~sv_q;

        always_comb begin
            // NOTE: every signal written here gets a default first, so no path can infer a latch.
            mv_d = mv_q;
            sv_d = sv_q;
            md_d = md_q;
            sd_d = sd_q;
            if (flush) begin
                mv_d = 1'b0;
                sv_d = 1'b0;
            end else if (~mv_q | m_ready) begin
                // Main is free this cycle: the skid beat is older, so it goes first.
                if (sv_q) begin
                    md_d = sd_q;
                    sv_d = 1'b0;
                end else if (accept) begin
                    md_d = s_data;
                    mv_d = 1'b1;
                end else begin
                    mv_d = 1'b0;
                end
            end else if (accept) begin
                sd_d = s_data;
                sv_d = 1'b1;
            end
        end

        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mv_q <= 1'b0;
                sv_q <= 1'b0;
            end else begin
                mv_q <= mv_d;
                sv_q <= sv_d;
            end
        end

        // NOTE: payload registers are deliberately left unreset; the valid bits alone say what is held.
        always_ff @(posedge clk) begin
            md_q <= md_d;
            sd_q <= sd_d;
        end

        assign s_ready = ~sv_q;
        assign m_valid = mv_q;
        assign m_data  = md_q;
    end else begin : g_reg
        logic             v_q, v_d;
        logic [WIDTH-1:0] d_q, d_d;

        assign s_ready = ~v_q | m_ready;

        always_comb begin
            v_d = v_q;
            d_d = d_q;
            if (flush) begin
                v_d = 1'b0;
            end else if (s_valid & s_ready) begin
                v_d = 1'b1;
                d_d = s_data;
            end else if (m_ready) begin
                v_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
            end else begin
                v_q <= v_d;
            end
        end

        always_ff @(posedge clk) begin
            d_q <= d_d;
        end

        assign m_valid = v_q;
        assign m_data  = d_q;
    end

endmodule

// File: rtl/axis_pipe_chain.sv
// DEPTH cascaded AXI-Stream register slices with synchronous flush and a live beat count.
// DEPTH=0 collapses to wires.
module axis_pipe_chain
    import axis_pipe_chain_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 2,
    parameter int REG_READY = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic [WIDTH-1:0]                        s_rx_tdata,
    input  logic                                    s_rx_tvalid,
    output logic                                    s_rx_tready,
    output logic [WIDTH-1:0]                        m_tx_tdata,
    output logic                                    m_tx_tvalid,
    input  logic                                    m_tx_tready,
    output logic [occ_width(DEPTH, REG_READY)-1:0]  occupancy,
    output logic                                    empty
);

    localparam int OCC_W = occ_width(DEPTH, REG_READY);

    if (DEPTH == 0) begin : g_wire
        logic unused_flush;
        assign unused_flush = flush;
        assign s_rx_tready  = m_tx_tready & ~rst;
        assign m_tx_tvalid  = s_rx_tvalid & ~rst;
        assign m_tx_tdata   = s_rx_tdata;
        assign occupancy    = '0;
        assign empty        = 1'b1;
    end else begin : g_chain
        logic [WIDTH-1:0] c_data [DEPTH+1];
        logic [DEPTH:0]   c_valid;
        logic [DEPTH:0]   c_ready;
        logic             s_xfer;
        logic             m_xfer;
        logic [OCC_W-1:0] occ_q, occ_d;

        // Flush blocks both ends so nothing crosses the boundary while the stages clear.
        assign c_data[0]      = s_rx_tdata;
        assign c_valid[0]     = s_rx_tvalid & ~flush;
        assign c_ready[DEPTH] = m_tx_tready & ~flush;

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            axis_skid_stage #(
                .WIDTH     (WIDTH),
                .REG_READY (REG_READY)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .s_data  (c_data[k]),
                .s_valid (c_valid[k]),
                .s_ready (c_ready[k]),
                .m_data  (c_data[k+1]),
                .m_valid (c_valid[k+1]),
                .m_ready (c_ready[k+1])
            );
        end

        assign s_rx_tready = c_ready[0] & ~flush & ~rst;
        assign m_tx_tvalid = c_valid[DEPTH] & ~flush;
        assign m_tx_tdata  = c_data[DEPTH];

        // Internal hand-offs keep the total constant, so only the two edges move the count.
        assign s_xfer = s_rx_tvalid & s_rx_tready;
        assign m_xfer = m_tx_tvalid & m_tx_tready;

        always_comb begin
            occ_d = occ_q;
            if (flush) begin
                occ_d = '0;
            end else if (s_xfer & ~m_xfer) begin
                occ_d = occ_q + 1'b1;
            end else if (m_xfer & ~s_xfer) begin
                occ_d = occ_q - 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end

        assign occupancy = occ_q;
        assign empty     = (occ_q == '0);
    end

endmodule

// File: tb/tb_axis_pipe_chain.sv
// Bench for axis_pipe_chain: directed scenarios plus a randomized stress run of several
// DEPTH/REG_READY variants against a beat-counting reference model.
module tb_axis_pipe_chain;
    import axis_pipe_chain_pkg::*;

    localparam int NI   = 7;
    localparam int W    = 32;
    localparam int CYC  = 30000;
    localparam int DEP [NI] = '{2, 3, 0, 1, 4, 1, 4};
    localparam int RR  [NI] = '{1, 1, 1, 0, 0, 1, 1};

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] vld, rdy, fl, s_rdy, m_vld, emp;
    logic [W-1:0]  din  [NI];
    logic [W-1:0]  dout [NI];
    int            occ  [NI];
    int            vectors = 0;
    int            miscompares = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int OW = occ_width(DEP[g], RR[g]);
        logic [OW-1:0] occ_w;
        axis_pipe_chain #(
            .WIDTH     (W),
            .DEPTH     (DEP[g]),
            .REG_READY (RR[g])
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .flush       (fl[g]),
            .s_rx_tdata  (din[g]),
            .s_rx_tvalid (vld[g]),
            .s_rx_tready (s_rdy[g]),
            .m_tx_tdata  (dout[g]),
            .m_tx_tvalid (m_vld[g]),
            .m_tx_tready (rdy[g]),
            .occupancy   (occ_w),
            .empty       (emp[g])
        );
        assign occ[g] = int'(occ_w);
    end

    // Payload of beat k on instance i: distinct per beat and per instance.
    function automatic logic [W-1:0] beat(input int i, input int k);
        logic [31:0] h;
        h = 32'(k) * 32'h9E37_79B1;
        return h ^ {8'(i), 24'h00_0000};
    endfunction

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld = '0;
        rdy = '1;
        fl  = '0;
        for (int i = 0; i < NI; i++) din[i] = '0;
        #2;
        for (int i = 0; i < NI; i++) begin
            vectors++; if (s_rdy[i] !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready[%0d]: got %b expected 0", i, s_rdy[i]); end
            vectors++; if (m_vld[i] !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid[%0d]: got %b expected 0", i, m_vld[i]); end
            vectors++; if (occ[i] !== 0) begin miscompares++; $display("FAIL reset_occupancy[%0d]: got %0d expected 0", i, occ[i]); end
            vectors++; if (emp[i] !== 1'b1) begin miscompares++; $display("FAIL reset_empty[%0d]: got %b expected 1", i, emp[i]); end
        end
        to_drive();
        rst = 1'b0;
        #1;
        vectors++; if (s_rdy[0] !== 1'b1) begin miscompares++; $display("FAIL post_reset_s_ready: got %b expected 1", s_rdy[0]); end
        vectors++; if (emp[0] !== 1'b1) begin miscompares++; $display("FAIL post_reset_empty: got %b expected 1", emp[0]); end
        // Park three beats in the chain with the sink stalled, then reset mid-cycle.
        rdy[0] = 1'b0;
        vld[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din[0] = 32'h100 + k;
            to_drive();
        end
        vld[0] = 1'b0;
        #1;
        vectors++; if (occ[0] !== 3) begin miscompares++; $display("FAIL held_occupancy: got %0d expected 3", occ[0]); end
        vectors++; if (m_vld[0] !== 1'b1) begin miscompares++; $display("FAIL held_m_valid: got %b expected 1", m_vld[0]); end
        #1;
        rst = 1'b1;
        #1;
        vectors++; if (m_vld[0] !== 1'b0) begin miscompares++; $display("FAIL async_rst_m_valid: got %b expected 0", m_vld[0]); end
        vectors++; if (occ[0] !== 0) begin miscompares++; $display("FAIL async_rst_occupancy: got %0d expected 0", occ[0]); end
        vectors++; if (s_rdy[0] !== 1'b0) begin miscompares++; $display("FAIL async_rst_s_ready: got %b expected 0", s_rdy[0]); end
        vectors++; if (emp[0] !== 1'b1) begin miscompares++; $display("FAIL async_rst_empty: got %b expected 1", emp[0]); end
        to_drive();
        rst = 1'b0;
        #1;
        vectors++; if (s_rdy[0] !== 1'b1) begin miscompares++; $display("FAIL release_s_ready: got %b expected 1", s_rdy[0]); end
        rdy[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            to_sample();
            vectors++; if (m_vld[0] !== 1'b0) begin miscompares++; $display("FAIL release_no_glitch c=%0d: got %b expected 0", c, m_vld[0]); end
        end
    endtask

    task automatic test_streaming();
        int exp_occ;
        logic exp_v;
        rdy[1] = 1'b1;
        for (int c = 0; c < 22; c++) begin
            to_drive();
            vld[1] = 1'(c < 16);
            din[1] = 32'(c);
            to_sample();
            if (c < 16) begin
                vectors++; if (s_rdy[1] !== 1'b1) begin miscompares++; $display("FAIL stream_s_ready c=%0d: got %b expected 1", c, s_rdy[1]); end
            end
            exp_v = 1'(c >= 3 && c < 19);
            vectors++; if (m_vld[1] !== exp_v) begin miscompares++; $display("FAIL stream_m_valid c=%0d: got %b expected %b", c, m_vld[1], exp_v); end
            if (exp_v) begin
                vectors++; if (dout[1] !== 32'(c - 3)) begin miscompares++; $display("FAIL stream_data c=%0d: got %h expected %h", c, dout[1], 32'(c - 3)); end
            end
            exp_occ = ((c < 16) ? c : 16) - ((c < 3) ? 0 : ((c - 3 < 16) ? c - 3 : 16));
            vectors++; if (occ[1] !== exp_occ) begin miscompares++; $display("FAIL stream_occupancy c=%0d: got %0d expected %0d", c, occ[1], exp_occ); end
        end
        vld[1] = 1'b0;
    endtask

    task automatic test_full_chain();
        int   accepted;
        logic exp_r;
        accepted = 0;
        rdy[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            to_drive();
            vld[0] = 1'b1;
            din[0] = 32'h200 + 32'(accepted);
            to_sample();
            exp_r = 1'(c < 4);
            vectors++; if (s_rdy[0] !== exp_r) begin miscompares++; $display("FAIL full_s_ready c=%0d: got %b expected %b", c, s_rdy[0], exp_r); end
            if (s_rdy[0]) accepted++;
        end
        to_drive();
        vld[0] = 1'b0;
        #1;
        vectors++; if (accepted !== 4) begin miscompares++; $display("FAIL full_accepted: got %0d expected 4", accepted); end
        vectors++; if (occ[0] !== 4) begin miscompares++; $display("FAIL full_occupancy: got %0d expected 4", occ[0]); end
        vectors++; if (s_rdy[0] !== 1'b0) begin miscompares++; $display("FAIL full_s_ready_low: got %b expected 0", s_rdy[0]); end
        rdy[0] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            to_sample();
            exp_r = 1'(c < 4);
            vectors++; if (m_vld[0] !== exp_r) begin miscompares++; $display("FAIL drain_m_valid c=%0d: got %b expected %b", c, m_vld[0], exp_r); end
            if (exp_r) begin
                vectors++; if (dout[0] !== 32'h200 + 32'(c)) begin miscompares++; $display("FAIL drain_data c=%0d: got %h expected %h", c, dout[0], 32'h200 + 32'(c)); end
            end
            to_drive();
        end
        #1;
        vectors++; if (occ[0] !== 0) begin miscompares++; $display("FAIL drain_occupancy: got %0d expected 0", occ[0]); end
        vectors++; if (emp[0] !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b expected 1", emp[0]); end
    endtask

    task automatic test_flush();
        logic seen;
        rdy[0] = 1'b0;
        vld[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din[0] = 32'h300 + 32'(k);
            to_drive();
        end
        fl[0]  = 1'b1;
        vld[0] = 1'b1;
        din[0] = 32'h77;
        rdy[0] = 1'b1;
        #1;
        vectors++; if (occ[0] !== 3) begin miscompares++; $display("FAIL flush_pre_occupancy: got %0d expected 3", occ[0]); end
        vectors++; if (s_rdy[0] !== 1'b0) begin miscompares++; $display("FAIL flush_s_ready: got %b expected 0", s_rdy[0]); end
        vectors++; if (m_vld[0] !== 1'b0) begin miscompares++; $display("FAIL flush_m_valid: got %b expected 0", m_vld[0]); end
        to_drive();
        fl[0]  = 1'b0;
        vld[0] = 1'b0;
        #1;
        vectors++; if (occ[0] !== 0) begin miscompares++; $display("FAIL flush_occupancy: got %0d expected 0", occ[0]); end
        vectors++; if (emp[0] !== 1'b1) begin miscompares++; $display("FAIL flush_empty: got %b expected 1", emp[0]); end
        vectors++; if (m_vld[0] !== 1'b0) begin miscompares++; $display("FAIL flush_after_m_valid: got %b expected 0", m_vld[0]); end
        din[0] = 32'hA5;
        vld[0] = 1'b1;
        #1;
        vectors++; if (s_rdy[0] !== 1'b1) begin miscompares++; $display("FAIL flush_accept_ready: got %b expected 1", s_rdy[0]); end
        to_drive();
        vld[0] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            to_sample();
            if (m_vld[0] && !seen) begin
                seen = 1'b1;
                vectors++; if (dout[0] !== 32'hA5) begin miscompares++; $display("FAIL flush_first_out: got %h expected 000000a5", dout[0]); end
            end
            to_drive();
        end
        vectors++; if (seen !== 1'b1) begin miscompares++; $display("FAIL flush_first_out_timeout: got no beat expected 000000a5"); end
    endtask

    task automatic test_depth0();
        for (int c = 0; c < 24; c++) begin
            to_drive();
            din[2] = $urandom;
            vld[2] = 1'($urandom_range(0, 1));
            rdy[2] = 1'($urandom_range(0, 1));
            fl[2]  = 1'($urandom_range(0, 1));
            #1;
            vectors++; if (dout[2] !== din[2]) begin miscompares++; $display("FAIL d0_data: got %h expected %h", dout[2], din[2]); end
            vectors++; if (m_vld[2] !== vld[2]) begin miscompares++; $display("FAIL d0_m_valid: got %b expected %b", m_vld[2], vld[2]); end
            vectors++; if (s_rdy[2] !== rdy[2]) begin miscompares++; $display("FAIL d0_s_ready: got %b expected %b", s_rdy[2], rdy[2]); end
            vectors++; if (occ[2] !== 0 || emp[2] !== 1'b1) begin miscompares++; $display("FAIL d0_occ_empty: got %0d/%b expected 0/1", occ[2], emp[2]); end
        end
        fl[2] = 1'b0;
        vld[2] = 1'b0;
    endtask

    task automatic test_random_stress();
        int sent [NI];
        int recv [NI];
        int held;
        int d;
        int r;
        logic [NI-1:0] snap;
        vld = '0;
        fl  = '0;
        rst = 1'b1;
        #1;
        to_drive();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            sent[i] = 0;
            recv[i] = 0;
        end
        for (int c = 0; c < CYC; c++) begin
            for (int i = 0; i < NI; i++) begin
                vld[i] = 1'($urandom_range(0, 1));
                rdy[i] = 1'($urandom_range(0, 1));
                fl[i]  = 1'($urandom_range(0, 199) == 0);
                din[i] = beat(i, sent[i]);
            end
            to_sample();
            // A registered-ready chain must not move s_rx_tready when only m_tx_tready changes.
            snap = s_rdy;
            rdy = ~rdy;
            #1;
            for (int i = 0; i < NI; i++) begin
                if (RR[i] != 0 && DEP[i] > 0) begin
                    vectors++; if (s_rdy[i] !== snap[i]) begin miscompares++; $display("FAIL ready_independent[%0d] c=%0d: got %b expected %b", i, c, s_rdy[i], snap[i]); end
                end
            end
            rdy = ~rdy;
            #1;
            for (int i = 0; i < NI; i++) begin
                held = sent[i] - recv[i];
                d = DEP[i];
                r = RR[i];
                if (d == 0) begin
                    vectors++; if (dout[i] !== din[i] || m_vld[i] !== vld[i] || s_rdy[i] !== rdy[i] || occ[i] !== 0) begin
                        miscompares++; $display("FAIL stress_d0[%0d] c=%0d: got %h/%b/%b/%0d expected %h/%b/%b/0", i, c, dout[i], m_vld[i], s_rdy[i], occ[i], din[i], vld[i], rdy[i]);
                    end
                end else begin
                    vectors++; if (occ[i] !== held) begin miscompares++; $display("FAIL stress_occupancy[%0d] c=%0d: got %0d expected %0d", i, c, occ[i], held); end
                    vectors++; if (emp[i] !== 1'(held == 0)) begin miscompares++; $display("FAIL stress_empty[%0d] c=%0d: got %b expected %b", i, c, emp[i], held == 0); end
                    vectors++; if (held > d * (1 + r)) begin miscompares++; $display("FAIL stress_capacity[%0d] c=%0d: got %0d expected <= %0d", i, c, held, d * (1 + r)); end
                    if (fl[i]) begin
                        vectors++; if ({s_rdy[i], m_vld[i]} !== 2'b00) begin miscompares++; $display("FAIL stress_flush_block[%0d] c=%0d: got %b%b expected 00", i, c, s_rdy[i], m_vld[i]); end
                    end else if (r == 0) begin
                        // A plain chain accepts whenever any slot is free or the sink takes a beat.
                        vectors++; if (s_rdy[i] !== 1'(held < d || rdy[i])) begin miscompares++; $display("FAIL stress_r0_ready[%0d] c=%0d: got %b expected %b", i, c, s_rdy[i], held < d || rdy[i]); end
                    end
                end
                if (m_vld[i] && rdy[i]) begin
                    vectors++;
                    if (d > 0 && held == 0) begin
                        miscompares++; $display("FAIL stress_phantom[%0d] c=%0d: got beat %h expected none", i, c, dout[i]);
                    end else begin
                        if (dout[i] !== beat(i, recv[i])) begin miscompares++; $display("FAIL stress_data[%0d] c=%0d: got %h expected %h", i, c, dout[i], beat(i, recv[i])); end
                        recv[i]++;
                    end
                end
                if (vld[i] && s_rdy[i]) sent[i]++;
                if (fl[i] && d > 0) recv[i] = sent[i];
            end
            to_drive();
        end
        vld = '0;
        fl  = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_streaming();
        test_full_chain();
        test_flush();
        test_depth0();
        test_random_stress();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
